// File: rtl/de_operand_unit.sv
// rtl/de_operand_unit.sv - operand fetch with scoreboard, writeback bypass and a registered issue latch
// Pending-write counters gate issue; a flushed latched writer returns its scoreboard slot.
module de_operand_unit #(
  parameter  int DBITS     = 32,
  parameter  int REGWORDS  = 32,
  parameter  int SBBITS    = 2,
  localparam int REGNOBITS = $clog2(REGWORDS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [REGNOBITS-1:0] in_rs1,
  input  logic [REGNOBITS-1:0] in_rs2,
  input  logic [REGNOBITS-1:0] in_rd,
  input  logic                 in_use_rs1,
  input  logic                 in_use_rs2,
  input  logic                 in_wr_reg,
  input  logic                 wb_valid,
  input  logic [REGNOBITS-1:0] wb_regno,
  input  logic [DBITS-1:0]     wb_data,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DBITS-1:0]     out_rs1_val,
  output logic [DBITS-1:0]     out_rs2_val,
  output logic [REGNOBITS-1:0] out_rd,
  output logic                 out_wr_reg,
  output logic                 stall,
  output logic                 busy
);

  logic [DBITS-1:0]                r_regs [REGWORDS];
  logic [REGWORDS-1:0][SBBITS-1:0] r_pend;
  logic [REGWORDS-1:0][SBBITS-1:0] w_pend_nxt;

  logic                 r_out_valid;
  logic [DBITS-1:0]     r_out_rs1_val;
  logic [DBITS-1:0]     r_out_rs2_val;
  logic [REGNOBITS-1:0] r_out_rd;
  logic                 r_out_wr_reg;

  logic             w_wb_en;
  logic             w_wb_rs1;
  logic             w_wb_rs2;
  logic             w_wb_rd;
  logic [DBITS-1:0] w_rs1_val;
  logic [DBITS-1:0] w_rs2_val;
  logic             w_rs1_haz;
  logic             w_rs2_haz;
  logic             w_rd_haz;
  logic             w_hazard;
  logic             w_accept;
  logic             w_flush_kill;

  assign w_wb_en  = wb_valid && (wb_regno != '0);
  assign w_wb_rs1 = w_wb_en && (wb_regno == in_rs1);
  assign w_wb_rs2 = w_wb_en && (wb_regno == in_rs2);
  assign w_wb_rd  = w_wb_en && (wb_regno == in_rd);

  assign w_rs1_val = (in_rs1 == '0) ? '0 : (w_wb_rs1 ? wb_data : r_regs[in_rs1]);
  assign w_rs2_val = (in_rs2 == '0) ? '0 : (w_wb_rs2 ? wb_data : r_regs[in_rs2]);

  // A single outstanding write retiring this cycle is covered by the bypass path.
  assign w_rs1_haz = in_use_rs1 && (in_rs1 != '0) && (r_pend[in_rs1] != '0) &&
                     !((r_pend[in_rs1] == SBBITS'(1)) && w_wb_rs1);
  assign w_rs2_haz = in_use_rs2 && (in_rs2 != '0) && (r_pend[in_rs2] != '0) &&
                     !((r_pend[in_rs2] == SBBITS'(1)) && w_wb_rs2);
  assign w_rd_haz  = in_wr_reg && (in_rd != '0) && (r_pend[in_rd] == '1) && !w_wb_rd;
  assign w_hazard  = w_rs1_haz || w_rs2_haz || w_rd_haz;

  assign in_ready = !reset && !flush && !w_hazard && (!r_out_valid || out_ready);
  assign w_accept = in_valid && in_ready;
  assign stall    = in_valid && w_hazard;
  assign busy     = |r_pend;

  assign w_flush_kill = flush && r_out_valid && r_out_wr_reg && (r_out_rd != '0);

  for (genvar g = 0; g < REGWORDS; g++) begin : g_sb
    logic          w_inc;
    logic          w_dec_wb;
    logic          w_dec_fl;
    logic [SBBITS:0] w_up;
    logic [SBBITS:0] w_down;

    assign w_inc    = w_accept && in_wr_reg && (in_rd == REGNOBITS'(g)) && (g != 0);
    assign w_dec_wb = w_wb_en && (wb_regno == REGNOBITS'(g));
    assign w_dec_fl = w_flush_kill && (r_out_rd == REGNOBITS'(g));
    assign w_up     = {1'b0, r_pend[g]} + (SBBITS+1)'(w_inc);
    assign w_down   = (SBBITS+1)'(w_dec_wb) + (SBBITS+1)'(w_dec_fl);
    // Net change is applied arithmetically and floors at zero.
    assign w_pend_nxt[g] = (w_up < w_down) ? '0 : SBBITS'(w_up - w_down);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend <= '0;
    end else begin
      r_pend <= w_pend_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < REGWORDS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wb_en) begin
      r_regs[wb_regno] <= wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid   <= 1'b0;
      r_out_rs1_val <= '0;
      r_out_rs2_val <= '0;
      r_out_rd      <= '0;
      r_out_wr_reg  <= 1'b0;
    end else if (w_accept) begin
      r_out_valid   <= 1'b1;
      r_out_rs1_val <= w_rs1_val;
      r_out_rs2_val <= w_rs2_val;
      r_out_rd      <= in_rd;
      r_out_wr_reg  <= in_wr_reg;
    end else if (flush || out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid   = r_out_valid;
  assign out_rs1_val = r_out_rs1_val;
  assign out_rs2_val = r_out_rs2_val;
  assign out_rd      = r_out_rd;
  assign out_wr_reg  = r_out_wr_reg;

endmodule

// File: tb/tb_de_operand_unit.sv
// tb/tb_de_operand_unit.sv - directed vector table plus hand sequences for de_operand_unit
module tb_de_operand_unit;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [4:0]  in_rd;
  logic        in_use_rs1;
  logic        in_use_rs2;
  logic        in_wr_reg;
  logic        wb_valid;
  logic [4:0]  wb_regno;
  logic [31:0] wb_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_rs1_val;
  logic [31:0] out_rs2_val;
  logic [4:0]  out_rd;
  logic        out_wr_reg;
  logic        stall;
  logic        busy;

  int n_cmp;
  int n_bad;

  de_operand_unit dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2), .in_wr_reg(in_wr_reg),
    .wb_valid(wb_valid), .wb_regno(wb_regno), .wb_data(wb_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val),
    .out_rd(out_rd), .out_wr_reg(out_wr_reg),
    .stall(stall), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [4:0]  rd;
    logic        u1;
    logic        u2;
    logic        wr;
    logic        wbv;
    logic [4:0]  wbn;
    logic [31:0] wbd;
    logic        fl;
    logic        ordy;
    logic        e_rdy;
    logic        e_stall;
    logic        e_ov;
    logic        chk;
    logic [31:0] e_v1;
    logic [31:0] e_v2;
    logic [4:0]  e_rd;
    logic        e_busy;
  } vec_t;

  vec_t tbl [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] rd, input logic u1, input logic u2, input logic wr,
                       input logic wbv, input logic [4:0] wbn, input logic [31:0] wbd,
                       input logic fl, input logic ordy);
    in_valid   = v;
    in_rs1     = r1;
    in_rs2     = r2;
    in_rd      = rd;
    in_use_rs1 = u1;
    in_use_rs2 = u2;
    in_wr_reg  = wr;
    wb_valid   = wbv;
    wb_regno   = wbn;
    wb_data    = wbd;
    flush      = fl;
    out_ready  = ordy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;

    tbl[0]  = '{1'b1, 5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0,        1'b0, 1'b1,
                1'b1, 1'b0, 1'b1, 1'b1, 32'h0,        32'h0,        5'd5, 1'b1};
    tbl[1]  = '{1'b1, 5'd5, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 1'b1,
                1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0,        5'd0, 1'b1};
    tbl[2]  = '{1'b1, 5'd5, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b1,
                1'b1, 1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 32'h0,        5'd0, 1'b0};
    tbl[3]  = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd2, 32'h11112222, 1'b0, 1'b1,
                1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        5'd0, 1'b0};
    tbl[4]  = '{1'b1, 5'd5, 5'd2, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 1'b1,
                1'b1, 1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 32'h11112222, 5'd0, 1'b0};
    tbl[5]  = '{1'b1, 5'd0, 5'd2, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd0, 32'h1234,     1'b0, 1'b1,
                1'b1, 1'b0, 1'b1, 1'b1, 32'h0,        32'h11112222, 5'd0, 1'b0};
    tbl[6]  = '{1'b1, 5'd2, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd2, 32'hCAFEF00D, 1'b0, 1'b1,
                1'b1, 1'b0, 1'b1, 1'b1, 32'hCAFEF00D, 32'h0,        5'd0, 1'b0};
    tbl[7]  = '{1'b1, 5'd2, 5'd5, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 1'b1,
                1'b1, 1'b0, 1'b1, 1'b1, 32'hCAFEF00D, 32'hDEADBEEF, 5'd0, 1'b0};
    tbl[8]  = '{1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 1'b1,
                1'b1, 1'b0, 1'b1, 1'b1, 32'h0,        32'h0,        5'd0, 1'b0};
    tbl[9]  = '{1'b1, 5'd0, 5'd0, 5'd9, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0,        1'b0, 1'b1,
                1'b1, 1'b0, 1'b1, 1'b1, 32'h0,        32'h0,        5'd9, 1'b1};
    tbl[10] = '{1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 1'b1,
                1'b1, 1'b0, 1'b1, 1'b1, 32'h0,        32'h0,        5'd0, 1'b1};
    tbl[11] = '{1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 1'b1,
                1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0,        5'd0, 1'b1};
    tbl[12] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 32'h99,       1'b0, 1'b1,
                1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        5'd0, 1'b0};

    reset = 1'b1;
    idle();
    tick();
    tick();
    check("reset in_ready", 32'(in_ready), 32'h0);
    check("reset out_valid", 32'(out_valid), 32'h0);
    check("reset busy", 32'(busy), 32'h0);
    check("reset out_rd", 32'(out_rd), 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].v, tbl[i].r1, tbl[i].r2, tbl[i].rd, tbl[i].u1, tbl[i].u2, tbl[i].wr,
            tbl[i].wbv, tbl[i].wbn, tbl[i].wbd, tbl[i].fl, tbl[i].ordy);
      #1;
      check($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(tbl[i].e_rdy));
      check($sformatf("vec%0d stall", i), 32'(stall), 32'(tbl[i].e_stall));
      tick();
      check($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
      check($sformatf("vec%0d busy", i), 32'(busy), 32'(tbl[i].e_busy));
      if (tbl[i].chk) begin
        check($sformatf("vec%0d rs1_val", i), out_rs1_val, tbl[i].e_v1);
        check($sformatf("vec%0d rs2_val", i), out_rs2_val, tbl[i].e_v2);
        check($sformatf("vec%0d out_rd", i), 32'(out_rd), 32'(tbl[i].e_rd));
      end
    end

    // Scoreboard saturation on rd=7: three writers fill the counter, the fourth waits.
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 5'd0, 5'd0, 5'd7, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
      #1;
      check($sformatf("sat accept%0d in_ready", k), 32'(in_ready), 32'h1);
      tick();
    end
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 5'd0, 5'd0, 5'd7, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
      #1;
      check($sformatf("sat full%0d stall", k), 32'(stall), 32'h1);
      check($sformatf("sat full%0d in_ready", k), 32'(in_ready), 32'h0);
      tick();
      check($sformatf("sat full%0d out_valid", k), 32'(out_valid), 32'h0);
    end
    drive(1'b1, 5'd0, 5'd0, 5'd7, 1'b0, 1'b0, 1'b1, 1'b1, 5'd7, 32'h77, 1'b0, 1'b1);
    #1;
    check("sat wb release stall", 32'(stall), 32'h0);
    check("sat wb release in_ready", 32'(in_ready), 32'h1);
    tick();
    check("sat fourth out_valid", 32'(out_valid), 32'h1);
    check("sat fourth out_rd", 32'(out_rd), 32'd7);
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 32'h77, 1'b0, 1'b1);
      tick();
      check($sformatf("sat drain%0d busy", k), 32'(busy), (k == 2) ? 32'h0 : 32'h1);
    end
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 32'h78, 1'b0, 1'b1);
    tick();
    check("sat no wrap busy", 32'(busy), 32'h0);

    // Backpressure: latched instruction must stay frozen while out_ready is low.
    drive(1'b1, 5'd2, 5'd0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    tick();
    check("bp first out_valid", 32'(out_valid), 32'h1);
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 5'd5, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
      #1;
      check($sformatf("bp%0d in_ready", k), 32'(in_ready), 32'h0);
      check($sformatf("bp%0d stall", k), 32'(stall), 32'h0);
      tick();
      check($sformatf("bp%0d out_valid", k), 32'(out_valid), 32'h1);
      check($sformatf("bp%0d rs1_val", k), out_rs1_val, 32'hCAFEF00D);
      check($sformatf("bp%0d out_rd", k), 32'(out_rd), 32'd4);
    end
    out_ready = 1'b1;
    #1;
    check("bp release in_ready", 32'(in_ready), 32'h1);
    tick();
    check("bp second out_valid", 32'(out_valid), 32'h1);
    check("bp second rs1_val", out_rs1_val, 32'hDEADBEEF);
    check("bp second out_rd", 32'(out_rd), 32'd8);
    idle();
    tick();
    check("bp drained out_valid", 32'(out_valid), 32'h0);

    // Flush of a latched writer to rd=3, alone and combined with a writeback.
    drive(1'b1, 5'd0, 5'd0, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    tick();
    check("fl latched busy", 32'(busy), 32'h1);
    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
    #1;
    check("fl in_ready", 32'(in_ready), 32'h0);
    tick();
    check("fl out_valid", 32'(out_valid), 32'h0);
    check("fl busy", 32'(busy), 32'h0);
    drive(1'b1, 5'd0, 5'd0, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
    tick();
    tick();
    check("fl two writers busy", 32'(busy), 32'h1);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 32'h33, 1'b1, 1'b1);
    tick();
    check("fl+wb out_valid", 32'(out_valid), 32'h0);
    check("fl+wb busy", 32'(busy), 32'h0);
    drive(1'b1, 5'd0, 5'd0, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 32'h34, 1'b1, 1'b0);
    tick();
    check("fl+wb floor busy", 32'(busy), 32'h0);
    check("fl+wb floor out_valid", 32'(out_valid), 32'h0);

    // Reset mid-operation discards the latch, the scoreboard and register contents.
    drive(1'b1, 5'd2, 5'd0, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    tick();
    check("rst pre out_valid", 32'(out_valid), 32'h1);
    check("rst pre busy", 32'(busy), 32'h1);
    reset = 1'b1;
    drive(1'b1, 5'd2, 5'd0, 5'd6, 1'b1, 1'b0, 1'b1, 1'b1, 5'd2, 32'h55, 1'b0, 1'b0);
    #1;
    check("rst in_ready", 32'(in_ready), 32'h0);
    tick();
    check("rst out_valid", 32'(out_valid), 32'h0);
    check("rst busy", 32'(busy), 32'h0);
    check("rst rs1_val", out_rs1_val, 32'h0);
    check("rst out_wr_reg", 32'(out_wr_reg), 32'h0);
    reset = 1'b0;
    drive(1'b1, 5'd2, 5'd5, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
    #1;
    check("post rst in_ready", 32'(in_ready), 32'h1);
    tick();
    check("post rst out_valid", 32'(out_valid), 32'h1);
    check("post rst reg2", out_rs1_val, 32'h0);
    check("post rst reg5", out_rs2_val, 32'h0);

    idle();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
